// File: rtl/button_debouncer.sv
// Push-button input conditioner: two-flop synchroniser plus independent
// per-button debounce counters, producing a clean level and one-cycle
// press/release pulses for each active-low button pin.
module button_debouncer #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] sw_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  // Last counter value before a change is accepted; never exceeded.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages reset to all-ones so an idle pin reads as released.
  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;

  // Synchronised pin state, 1 = pressed.
  logic [NUM_BTN-1:0] sample;

  // Per-button debounce counters.
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // Next-state values for the registered outputs.
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] release_d;
  logic               any_press_d;

  assign sample = ~sync_q2;

  // Two-flop synchroniser on the asynchronous button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= sw_n;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce decision: count consecutive disagreeing cycles, accept on the last.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sample[i] == btn_level[i]) begin
        // Any return to the accepted level discards the partial count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i]   = sample[i];
        cnt_d[i]     = '0;
        press_d[i]   = sample[i];
        release_d[i] = ~sample[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    any_press_d = |press_d;
  end

  // Counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      any_press   <= any_press_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, NUM_BTN=4.
module tb_button_debouncer;

  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst;
  logic [NB-1:0] sw_n;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  int total;
  int bad;

  button_debouncer #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_n        (sw_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] lvl, input logic [NB-1:0] prs,
                         input logic [NB-1:0] rel, input logic anyp);
    chk({tag, ".level"},   32'(btn_level),   32'(lvl));
    chk({tag, ".press"},   32'(btn_press),   32'(prs));
    chk({tag, ".release"}, 32'(btn_release), 32'(rel));
    chk({tag, ".any"},     32'(any_press),   32'(anyp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sw_n  = 4'b1111;
    rst   = 1'b1;

    // Scenario 6: idle power-up reset, no pulses during or after it.
    #2;
    chk_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Scenario 1: clean press of button 0.
    sw_n = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("press_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk_all("press_accept", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    step();
    chk_all("press_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Scenario 2: button 1 bounces with 3-clock phases, never accepted.
    for (int p = 0; p < 4; p++) begin
      sw_n[1] = p[0];
      for (int i = 0; i < 3; i++) begin
        step();
        chk_all("bounce", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      end
    end
    sw_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_all("bounce_tail", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // Scenario 3: release of button 0.
    sw_n = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("rel_wait", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk_all("rel_accept", 4'b0000, 4'b0000, 4'b0001, 1'b0);
    step();
    chk_all("rel_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Scenario 4: buttons 1 and 3 pressed on the same clock.
    sw_n = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("sim_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk_all("sim_accept", 4'b1010, 4'b1010, 4'b0000, 1'b1);
    step();
    chk_all("sim_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // Scenario 5: button 2 pressed, reset after two counted clocks.
    sw_n = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("mid_wait", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk_all("mid_rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("mid_rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("post_rst_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk_all("post_rst_accept", 4'b0100, 4'b0100, 4'b0000, 1'b1);
    step();
    chk_all("post_rst_after", 4'b0100, 4'b0000, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
